// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port byte-wide data memory.
// Requester 0 is the CPU LSU; requester 1 is the text writer, confined to the display window.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  parameter int CHAR_WORDS = 18,
  parameter bit RR         = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              rdy0,
  output logic              rdy1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [ADDR_W-3:0] CHAR_LIM = (ADDR_W-2)'(CHAR_WORDS);

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic              blk_q, blk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              sel;

  always_comb begin
    // Tie goes to the requester that did not win last (RR) or always to 0.
    if (req0 && req1) sel = RR ? ~last_gnt_q : 1'b0;
    else              sel = req1;
    rdy0 = (state_q == IDLE) && req0 && !sel;
    rdy1 = (state_q == IDLE) && req1 &&  sel;

    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    id_d       = id_q;
    we_d       = we_q;
    blk_d      = blk_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err1_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rdy0 || rdy1) begin
          id_d       = sel;
          we_d       = sel ? we1    : we0;
          addr_d     = sel ? addr1  : addr0;
          wdata_d    = sel ? wdata1 : wdata0;
          blk_d      = sel && we1 && (addr1[ADDR_W-1:2] >= CHAR_LIM);
          last_gnt_d = sel;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (id_q) begin
          done1_d = 1'b1;
          err1_d  = blk_q;
          if (!we_q) rdata1_d = mem_rd;
        end else begin
          done0_d = 1'b1;
          if (!we_q) rdata0_d = mem_rd;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      blk_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      id_q       <= id_d;
      we_q       <= we_d;
      blk_q      <= blk_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err1_q     <= err1_d;
    end
  end

  // Write enable is decoded from state so an async reset kills it at once.
  assign mem_we = (state_q == ACCESS) && we_q && !blk_q;
  assign mem_a  = addr_q;
  assign mem_wd = wdata_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign err1   = err1_q;

endmodule
